// File: rtl/pdm_pkg.sv
// Shared types, default parameters and conversion helper for the PDM decimator.
package pdm_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StRun
  } pdm_state_e;

  localparam int unsigned DefClkDiv    = 40;
  localparam int unsigned DefDecim     = 64;
  localparam int unsigned DefOutW      = 16;
  localparam int unsigned DefSettleWin = 4;
  localparam int unsigned FifoDepth    = 4;

  // Boxcar ones-count to signed PCM: 2*ones - decim, range -decim..+decim.
  function automatic int ones_to_pcm(input int unsigned ones, input int unsigned decim);
    return 2 * int'(ones) - int'(decim);
  endfunction

endpackage

// File: rtl/pdm_clkgen.sv
// PDM clock divider: free-running 0..CLK_DIV-1 count, registered m_clk and a
// one-cycle sample_tick on the last count; held at zero while not running.
module pdm_clkgen
  import pdm_pkg::*;
#(
  parameter int unsigned CLK_DIV = DefClkDiv
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic run,
  output logic m_clk,
  output logic sample_tick
);

  localparam int unsigned CntW = $clog2(CLK_DIV);
  localparam logic [CntW-1:0] CntMax  = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLK_DIV / 2);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            m_clk_q, m_clk_d;

  // m_clk is computed from the next count so it lines up with the count value;
  // en alone (not run) lets the first high phase start with count 0.
  always_comb begin
    cnt_d = '0;
    if (run && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntW'(1);
    end
    m_clk_d = en && (cnt_d < CntHalf);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      m_clk_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      m_clk_q <= m_clk_d;
    end
  end

  assign m_clk       = m_clk_q;
  assign sample_tick = run && (cnt_q == CntMax);

endmodule

// File: rtl/pdm_decimator.sv
// PDM microphone front end: clock generation, boxcar decimation and a PCM
// valid/ready output. Define PDM_FIFO_EN for a 4-entry output FIFO.
module pdm_decimator
  import pdm_pkg::*;
#(
  parameter int unsigned CLK_DIV    = DefClkDiv,
  parameter int unsigned DECIM      = DefDecim,
  parameter int unsigned OUT_W      = DefOutW,
  parameter int unsigned SETTLE_WIN = DefSettleWin
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             m_data,
  output logic             m_clk,
  output logic             m_lrsel,
  output logic [OUT_W-1:0] pcm_data,
  output logic             pcm_valid,
  input  logic             pcm_ready,
  output logic             overrun,
  input  logic             clr_overrun
);

  localparam int unsigned OnesW = $clog2(DECIM + 1);
  localparam int unsigned BitW  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int unsigned SetW  = (SETTLE_WIN > 1) ? $clog2(SETTLE_WIN) : 1;
  localparam logic [BitW-1:0] BitMax = BitW'(DECIM - 1);
  localparam logic [SetW-1:0] SetMax = SetW'((SETTLE_WIN > 0) ? SETTLE_WIN - 1 : 0);

  pdm_state_e       state_q, state_d;
  logic [1:0]       sync_q;
  logic             m_bit;
  logic             run;
  logic             sample_tick;
  logic [OnesW-1:0] ones_q, ones_d, win_ones;
  logic [BitW-1:0]  bitcnt_q, bitcnt_d;
  logic [SetW-1:0]  settle_q, settle_d;
  logic             win_close;
  logic             load;
  logic             drop;
  logic [OUT_W-1:0] sample;
  logic             overrun_q, overrun_d;

  assign m_bit   = sync_q[1];
  assign run     = (state_q != StIdle) && en;
  assign m_lrsel = 1'b0;

  pdm_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .run         (run),
    .m_clk       (m_clk),
    .sample_tick (sample_tick)
  );

  always_comb begin
    ones_d    = ones_q;
    bitcnt_d  = bitcnt_q;
    win_close = 1'b0;
    win_ones  = ones_q + OnesW'(m_bit);
    if (!run) begin
      ones_d   = '0;
      bitcnt_d = '0;
    end else if (sample_tick) begin
      if (bitcnt_q == BitMax) begin
        win_close = 1'b1;
        ones_d    = '0;
        bitcnt_d  = '0;
      end else begin
        ones_d   = win_ones;
        bitcnt_d = bitcnt_q + BitW'(1);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    if (!en) begin
      state_d  = StIdle;
      settle_d = '0;
    end else begin
      case (state_q)
        StIdle:   state_d = (SETTLE_WIN == 0) ? StRun : StSettle;
        StSettle: begin
          if (win_close) begin
            if (settle_q == SetMax) begin
              state_d  = StRun;
              settle_d = '0;
            end else begin
              settle_d = settle_q + SetW'(1);
            end
          end
        end
        StRun:    state_d = StRun;
        default:  state_d = StIdle;
      endcase
    end
  end

  assign sample = OUT_W'(ones_to_pcm(32'(win_ones), DECIM));
  assign load   = win_close && (state_q == StRun);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      sync_q    <= '0;
      ones_q    <= '0;
      bitcnt_q  <= '0;
      settle_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[0], m_data};
      ones_q    <= ones_d;
      bitcnt_q  <= bitcnt_d;
      settle_q  <= settle_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef PDM_FIFO_EN
  localparam int unsigned PtrW = $clog2(FifoDepth);

  logic [OUT_W-1:0] fifo_q [FifoDepth];
  logic [PtrW-1:0]  wr_q, rd_q;
  logic [PtrW:0]    cnt_q;
  logic             push, pop, full;

  assign full = (cnt_q == (PtrW + 1)'(FifoDepth));
  assign pop  = (cnt_q != '0) && pcm_ready;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push = load && (!full || pop);
  assign drop = load && full && !pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FifoDepth; i++) begin
        fifo_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_q] <= sample;
        wr_q         <= wr_q + PtrW'(1);
      end
      if (pop) begin
        rd_q <= rd_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (PtrW + 1)'(1);
        2'b01:   cnt_q <= cnt_q - (PtrW + 1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign pcm_valid = (cnt_q != '0);
  assign pcm_data  = fifo_q[rd_q];
`else
  logic [OUT_W-1:0] hold_q;
  logic             valid_q;
  logic             xfer;

  assign xfer = valid_q && pcm_ready;
  assign drop = load && valid_q && !xfer;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q  <= '0;
      valid_q <= 1'b0;
    end else if (load && (!valid_q || xfer)) begin
      hold_q  <= sample;
      valid_q <= 1'b1;
    end else if (xfer) begin
      valid_q <= 1'b0;
    end
  end

  assign pcm_valid = valid_q;
  assign pcm_data  = hold_q;
`endif

  // A drop in the same cycle as a clear leaves the flag set.
  always_comb begin
    overrun_d = overrun_q;
    if (drop) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end
  end

  assign overrun = overrun_q;

endmodule
